vector_hazard_ctrl: RTL and testbench
=====================================

# vector_hazard_ctrl

Pipeline controller for the five-stage core: it sequences multi-element vectorial instructions through the 32-bit execute stage one element per cycle and freezes the front end while doing so. It also resolves load-use hazards and taken-branch flushes between decode and execute. It sits beside `decode_cycle`, and drives the enable and flush inputs of the fetch, decode and execute pipeline registers.

## Interface
Parameters:
- `LANES`, default 4: elements per vectorial instruction; legal values are 1 to 16.
- `ELEM_W`, default 2: width of the element index, equal to `$clog2(LANES)` with a minimum of 1.
- `CNT_W`, default 16: width of the stall-cycle performance counter.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `vectorialE`, input, 1: the instruction in execute is vectorial.
- `ResultSrcE`, input, 1: the instruction in execute is a load.
- `RD_E`, input, 6: destination register of the execute instruction.
- `RS1_D`, input, 6: source 1 of the decode instruction.
- `RS2_D`, input, 6: source 2 of the decode instruction.
- `PCSrcE`, input, 1: taken branch resolved in execute.
- `StallF`, output, 1: hold PC.
- `StallD`, output, 1: hold the decode register.
- `StallE`, output, 1: hold the execute register, so the vector instruction is replayed.
- `FlushD`, output, 1: clear the decode register.
- `FlushE`, output, 1: clear the execute register, inserting a bubble.
- `ElemIdxE`, output, `ELEM_W`: element index being processed in execute.
- `VecBusy`, output, 1: a vectorial sequence is in progress.
- `VecDone`, output, 1: the last element of the vector is in execute this cycle.
- `StallCnt`, output, `CNT_W`: saturating count of cycles with `StallF`=1.

## Operation
- FSM states:
  - `IDLE`: element counter = 0.
  - `RUN`: element counter = 1 to `LANES`-1.
- Transitions:
  - In `IDLE` with `vectorialE`=1 and `LANES`>1, go to `RUN` with counter ← 1.
  - In `RUN`, counter ← counter+1 each cycle. When counter = `LANES`-1, the next state is `IDLE` and the counter returns to 0.
  - With `LANES`=1, the FSM never leaves `IDLE`.
- Outputs are Mealy, combinational from state and inputs:
  - `ElemIdxE` = counter.
  - `VecBusy` = (state==`RUN`) OR (`IDLE` AND `vectorialE`).
  - `VecDone` = `VecBusy` AND counter==`LANES`-1.
- Vector hold: when `VecBusy` AND NOT `VecDone`, assert `StallF`=`StallD`=`StallE`=1 and `FlushE`=0.
- Load-use hazard, `lu` = `ResultSrcE` AND `RD_E`≠0 AND (`RD_E`==`RS1_D` OR `RD_E`==`RS2_D`):
  - Gives `StallF`=`StallD`=1 and `FlushE`=1 for one cycle.
  - Evaluated only when `VecBusy`=0.
- Branch: `PCSrcE`=1 AND `VecBusy`=0 gives `FlushD`=`FlushE`=1.
- `PCSrcE` is ignored while `VecBusy`=1, because vectorial instructions never branch.
- Priority, highest first:
  1. Vector hold.
  2. Branch flush. On branch plus `lu`, the flush wins and the stalls are 0.
  3. Load-use.
- `StallCnt`: increments by 1 in every cycle with `StallF`=1 and saturates at all-ones; it does not wrap.
- Register 0 never causes a hazard.

## Timing
- Reset (`rst` sampled high at a `clk` edge): state ← `IDLE`, counter ← 0, `StallCnt` ← 0.
- After reset with idle inputs, every output is 0.
- Reset mid-sequence aborts the vector. State is `IDLE` on the next cycle and the stall outputs drop unless inputs request them again.
- A vector instruction occupies execute for exactly `LANES` consecutive cycles, with `ElemIdxE` = 0, 1, …, `LANES`-1.
- Stall outputs are high for the first `LANES`-1 of those cycles. On the `VecDone` cycle the stalls are 0, so the pipeline advances at the next edge.
- A back-to-back vector (next `vectorialE`=1 directly after `VecDone`) starts a fresh sequence at `ElemIdxE`=0 with no idle cycle.
- A load-use stall lasts exactly one cycle per hazard, for a 1-bubble penalty.
- Branch flush penalty is 2 cycles, applied the same cycle as `PCSrcE`.
- There are no outputs registered beyond the FSM and the counter, so control reaches the pipeline-register enables in the same cycle.

## Test plan
1. Reset: hold `rst`=1 for 2 cycles with random inputs, then drive all inputs to 0. Required: all outputs 0 and `StallCnt`=0.
2. Vector sequence, `LANES`=4: hold `vectorialE`=1 for 4 cycles. Required:
   - `ElemIdxE` = 0, 1, 2, 3.
   - `StallF`/`StallD`/`StallE` = 1, 1, 1, 0.
   - `VecDone` high only on cycle 4.
   - `StallCnt`=3 afterwards.
3. Load-use: `ResultSrcE`=1, `RD_E`=5, `RS2_D`=5. Required: `StallF`=`StallD`=`FlushE`=1 for one cycle. Repeating with `RD_E`=0 must give no stall.
4. Branch plus load-use in the same cycle: `PCSrcE`=1 and `lu`=1. Required: `FlushD`=`FlushE`=1 and `StallF`=0.
5. Branch during vector: `PCSrcE`=1 while `ElemIdxE`=1. Required: `FlushD`=0, and the sequence completes through index 3 unchanged.
6. Reset mid-vector: assert `rst` at `ElemIdxE`=2 with `vectorialE` dropped. Required: the next cycle has `VecBusy`=0, `ElemIdxE`=0 and `StallCnt`=0. A separate run that holds `StallF` for 2^`CNT_W`+5 cycles must leave `StallCnt` saturated at 0xFFFF.

Source files
------------

// File: rtl/vector_hazard_ctrl.sv
// Pipeline hazard controller: sequences vectorial instructions through execute one
// element per cycle, resolves load-use stalls and taken-branch flushes.
module vector_hazard_ctrl #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned ELEM_W = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vectorialE,
    input  logic              ResultSrcE,
    input  logic [5:0]        RD_E,
    input  logic [5:0]        RS1_D,
    input  logic [5:0]        RS2_D,
    input  logic              PCSrcE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic [ELEM_W-1:0] ElemIdxE,
    output logic              VecBusy,
    output logic              VecDone,
    output logic [CNT_W-1:0]  StallCnt
);

    localparam int unsigned       LAST_IDX   = LANES - 1;
    localparam bit                MULTI_LANE = (LANES > 1);
    localparam logic [ELEM_W-1:0] LAST_ELEM  = ELEM_W'(LAST_IDX);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [ELEM_W-1:0] elem_q, elem_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              load_use;
    logic              vec_hold;

    // State and element counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            elem_q  <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
        end
    end

    // Next state plus Mealy control outputs
    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        VecBusy  = 1'b0;
        VecDone  = 1'b0;
        ElemIdxE = elem_q;
        vec_hold = 1'b0;
        load_use = 1'b0;

        case (state_q)
            IDLE: begin
                elem_d = '0;
                if (vectorialE && MULTI_LANE) begin
                    state_d = RUN;
                    elem_d  = ELEM_W'(1);
                end
            end
            RUN: begin
                if (elem_q == LAST_ELEM) begin
                    state_d = IDLE;
                    elem_d  = '0;
                end else begin
                    elem_d = elem_q + ELEM_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                elem_d  = '0;
            end
        endcase

        VecBusy  = (state_q == RUN) || vectorialE;
        VecDone  = VecBusy && (elem_q == LAST_ELEM);
        vec_hold = VecBusy && !VecDone;

        // Register 0 is hardwired zero, so it never forms a dependency
        load_use = ResultSrcE && (RD_E != 6'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));

        if (vec_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
        end else if (!VecBusy && PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (!VecBusy && load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    // Saturating count of front-end stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_vector_hazard_ctrl.sv
// Self-checking bench for vector_hazard_ctrl: directed scenarios plus random
// stimulus against a cycle-level behavioural model of the hazard rules.
module tb_vector_hazard_ctrl;

    localparam int LANES  = 4;
    localparam int ELEM_W = 2;
    localparam int CNT_W  = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              vectorialE;
    logic              ResultSrcE;
    logic [5:0]        RD_E;
    logic [5:0]        RS1_D;
    logic [5:0]        RS2_D;
    logic              PCSrcE;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              FlushD;
    logic              FlushE;
    logic [ELEM_W-1:0] ElemIdxE;
    logic              VecBusy;
    logic              VecDone;
    logic [CNT_W-1:0]  StallCnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: is a vector instruction mid-flight, which element is next, stall count
    bit m_in_vec;
    int m_elem;
    int m_cnt;

    bit e_sf, e_sd, e_se, e_fd, e_fe, e_busy, e_done;
    int e_idx;

    vector_hazard_ctrl #(.LANES(LANES), .ELEM_W(ELEM_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .vectorialE(vectorialE), .ResultSrcE(ResultSrcE),
        .RD_E(RD_E), .RS1_D(RS1_D), .RS2_D(RS2_D), .PCSrcE(PCSrcE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
        .FlushE(FlushE), .ElemIdxE(ElemIdxE), .VecBusy(VecBusy), .VecDone(VecDone),
        .StallCnt(StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_eval();
        bit lu;
        e_busy = m_in_vec || vectorialE;
        e_idx  = m_in_vec ? m_elem : 0;
        e_done = e_busy && (e_idx == LANES - 1);
        lu = ResultSrcE && (RD_E != 0) && (RD_E == RS1_D || RD_E == RS2_D);
        {e_sf, e_sd, e_se, e_fd, e_fe} = 5'b0;
        if (e_busy && !e_done)     {e_sf, e_sd, e_se} = 3'b111;
        else if (!e_busy && PCSrcE) {e_fd, e_fe} = 2'b11;
        else if (!e_busy && lu)     {e_sf, e_sd, e_fe} = 3'b111;
    endtask

    task automatic model_advance();
        if (rst) begin
            m_in_vec = 1'b0;
            m_elem   = 0;
            m_cnt    = 0;
        end else begin
            if (e_sf && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (e_busy && !e_done) begin
                m_in_vec = 1'b1;
                m_elem   = e_idx + 1;
            end else begin
                m_in_vec = 1'b0;
                m_elem   = 0;
            end
        end
    endtask

    // Drive inputs just after an edge and let the combinational outputs settle
    task automatic set_in(input bit r, input bit v, input bit ls, input logic [5:0] rd,
                          input logic [5:0] rs1, input logic [5:0] rs2, input bit br);
        rst = r; vectorialE = v; ResultSrcE = ls; RD_E = rd; RS1_D = rs1; RS2_D = rs2; PCSrcE = br;
        #3;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 1'($urandom), 1'($urandom), 6'($urandom), 6'($urandom), 6'($urandom), 1'($urandom));
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        n_checks++;
        if ({StallF, StallD, StallE, FlushD, FlushE, VecBusy, VecDone} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {StallF, StallD, StallE, FlushD, FlushE, VecBusy, VecDone});
        end
        n_checks++;
        if (ElemIdxE !== '0) begin
            n_fail++;
            $display("FAIL reset_idx: got %0d expected 0", ElemIdxE);
        end
        n_checks++;
        if (StallCnt !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d expected 0", StallCnt);
        end
        tick();
    endtask

    task automatic test_vector();
        int cnt0 = m_cnt;
        for (int i = 0; i < LANES; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
            n_checks++;
            if (ElemIdxE !== ELEM_W'(i)) begin
                n_fail++;
                $display("FAIL vec_idx[%0d]: got %0d expected %0d", i, ElemIdxE, i);
            end
            n_checks++;
            if ({StallF, StallD, StallE} !== {3{i < LANES - 1}}) begin
                n_fail++;
                $display("FAIL vec_stall[%0d]: got %b expected %b", i, {StallF, StallD, StallE}, {3{i < LANES - 1}});
            end
            n_checks++;
            if ({VecDone, VecBusy, FlushE} !== {i == LANES - 1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL vec_done[%0d]: got done/busy/flushE %b expected %b", i,
                         {VecDone, VecBusy, FlushE}, {i == LANES - 1, 1'b1, 1'b0});
            end
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        n_checks++;
        if (int'(StallCnt) !== cnt0 + LANES - 1 || VecBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL vec_after: got cnt %0d busy %b expected cnt %0d busy 0", StallCnt, VecBusy, cnt0 + LANES - 1);
        end
        tick();
    endtask

    task automatic test_load_use();
        set_in(1'b0, 1'b0, 1'b1, 6'd5, 6'd9, 6'd5, 1'b0);
        n_checks++;
        if ({StallF, StallD, StallE, FlushD, FlushE} !== 5'b11001) begin
            n_fail++;
            $display("FAIL load_use: got %b expected 11001", {StallF, StallD, StallE, FlushD, FlushE});
        end
        tick();
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        n_checks++;
        if ({StallF, FlushE} !== 2'b00) begin
            n_fail++;
            $display("FAIL load_use_one_cycle: got %b expected 00", {StallF, FlushE});
        end
        tick();
        set_in(1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 6'd0, 1'b0);
        n_checks++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            n_fail++;
            $display("FAIL load_use_r0: got %b expected 000", {StallF, StallD, FlushE});
        end
        tick();
        set_in(1'b0, 1'b0, 1'b1, 6'd33, 6'd33, 6'd2, 1'b0);
        n_checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            n_fail++;
            $display("FAIL load_use_rs1: got %b expected 111", {StallF, StallD, FlushE});
        end
        tick();
    endtask

    task automatic test_branch_lu();
        set_in(1'b0, 1'b0, 1'b1, 6'd7, 6'd7, 6'd7, 1'b1);
        n_checks++;
        if ({StallF, StallD, StallE, FlushD, FlushE} !== 5'b00011) begin
            n_fail++;
            $display("FAIL branch_lu: got %b expected 00011", {StallF, StallD, StallE, FlushD, FlushE});
        end
        tick();
    endtask

    task automatic test_branch_in_vector();
        for (int i = 0; i < LANES; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0, i == 1);
            n_checks++;
            if ({FlushD, ElemIdxE, StallF} !== {1'b0, ELEM_W'(i), i < LANES - 1}) begin
                n_fail++;
                $display("FAIL branch_in_vec[%0d]: got flushD/idx/stallF %b/%0d/%b expected 0/%0d/%b",
                         i, FlushD, ElemIdxE, StallF, i, i < LANES - 1);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2 * LANES; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
            n_checks++;
            if ({ElemIdxE, VecDone} !== {ELEM_W'(i % LANES), (i % LANES) == LANES - 1}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got idx %0d done %b expected idx %0d done %b",
                         i, ElemIdxE, VecDone, i % LANES, (i % LANES) == LANES - 1);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_vector();
        set_in(1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        tick();
        tick();
        set_in(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        n_checks++;
        if ({ElemIdxE, VecBusy} !== {ELEM_W'(2), 1'b1}) begin
            n_fail++;
            $display("FAIL mid_vec_pre: got idx %0d busy %b expected idx 2 busy 1", ElemIdxE, VecBusy);
        end
        tick();
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        n_checks++;
        if ({VecBusy, ElemIdxE, StallF} !== {1'b0, ELEM_W'(0), 1'b0} || StallCnt !== '0) begin
            n_fail++;
            $display("FAIL mid_vec_reset: got busy %b idx %0d stallF %b cnt %0d expected 0 0 0 0",
                     VecBusy, ElemIdxE, StallF, StallCnt);
        end
        tick();
    endtask

    task automatic test_random();
        logic [26:0] got, exp;
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
                   6'($urandom_range(0, 6)), 6'($urandom_range(0, 6)), 6'($urandom_range(0, 6)),
                   $urandom_range(0, 4) == 0);
            got = {StallF, StallD, StallE, FlushD, FlushE, VecBusy, VecDone, ElemIdxE, StallCnt};
            exp = {e_sf, e_sd, e_se, e_fd, e_fe, e_busy, e_done, ELEM_W'(e_idx), CNT_W'(m_cnt)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        set_in(1'b1, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b1, 6'd5, 6'd5, 6'd0, 1'b0);
        for (int i = 0; i < CNT_MAX - 1; i++) tick();
        n_checks++;
        if (int'(StallCnt) !== CNT_MAX - 1 || m_cnt != CNT_MAX - 1) begin
            n_fail++;
            $display("FAIL sat_near: got %0d expected %0d", StallCnt, CNT_MAX - 1);
        end
        for (int i = 0; i < 7; i++) tick();
        n_checks++;
        if (StallCnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: got %h expected ffff", StallCnt);
        end
        set_in(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        tick();
    endtask

    initial begin
        m_in_vec = 1'b0;
        m_elem   = 0;
        m_cnt    = 0;
        test_reset();
        test_vector();
        test_load_use();
        test_branch_lu();
        test_branch_in_vector();
        test_back_to_back();
        test_reset_mid_vector();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
